// File: rtl/issue_entry_queue_pkg.sv
`default_nettype none
// ============================================================================
// issue_entry_queue_pkg: entry types shared by the issue entry queue slice.
// Revision: 1.0
// ============================================================================
package issue_entry_queue_pkg;

  typedef enum logic [2:0] {
    FU_NONE      = 3'd0,
    FU_LOAD      = 3'd1,
    FU_STORE     = 3'd2,
    FU_ALU       = 3'd3,
    FU_CTRL_FLOW = 3'd4,
    FU_MULT      = 3'd5,
    FU_CSR       = 3'd6
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_ctrl_flow;
  } issue_q_entry_t;

  function automatic bit is_valid_depth(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_entry_queue_if.sv
`default_nettype none
// ============================================================================
// issue_entry_queue_if: decode-side push, reorder-side pop and lookahead view.
// Revision: 1.0
// ============================================================================
interface issue_entry_queue_if
  import issue_entry_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  logic                         flush_i;
  scoreboard_entry_t            issue_entry_i;
  logic                         issue_entry_valid_i;
  logic                         is_ctrl_flow_i;
  logic                         issue_instr_ack_o;
  scoreboard_entry_t            issue_entry_o;
  logic                         issue_entry_valid_o;
  logic                         is_ctrl_flow_o;
  logic                         issue_instr_ack_i;
  scoreboard_entry_t            next_entry_o;
  logic                         next_entry_valid_o;
  logic [$clog2(DEPTH+1)-1:0]   usage_o;

  modport master (
    output flush_i, issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_i,
    input  issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o,
           next_entry_o, next_entry_valid_o, usage_o
  );

  modport slave (
    input  flush_i, issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_i,
    output issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o,
           next_entry_o, next_entry_valid_o, usage_o
  );
endinterface
`default_nettype wire

// File: rtl/issue_entry_queue.sv
`default_nettype none
// ============================================================================
// issue_entry_queue: circular buffer between decode and reorder, head + lookahead.
// Revision: 1.0
// ============================================================================
module issue_entry_queue
  import issue_entry_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  issue_entry_queue_if.slave q
);

  localparam int unsigned        c_PTR_W = $clog2(DEPTH);
  localparam int unsigned        c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_TWO   = c_CNT_W'(2);

  issue_q_entry_t     r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] w_rd_ptr_nxt;
  logic [c_CNT_W-1:0] r_usage;
  logic               w_push;
  logic               w_pop;
  logic               w_head_valid;
  logic               w_next_valid;

  // A full queue refuses pushes even when the head pops, so ack_i never reaches ack_o.
  assign w_push       = q.issue_entry_valid_i && (r_usage < c_FULL) && !q.flush_i;
  assign w_head_valid = (r_usage != '0) && !q.flush_i;
  assign w_next_valid = (r_usage >= c_TWO) && !q.flush_i;
  assign w_pop        = q.issue_instr_ack_i && w_head_valid;
  assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i || q.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_usage <= r_usage + c_CNT_W'(1);
        2'b01:   r_usage <= r_usage - c_CNT_W'(1);
        default: r_usage <= r_usage;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr].sbe          <= q.issue_entry_i;
      r_mem[r_wr_ptr].is_ctrl_flow <= q.is_ctrl_flow_i;
    end
  end

  assign q.issue_instr_ack_o   = w_push;
  assign q.issue_entry_valid_o = w_head_valid;
  assign q.issue_entry_o       = w_head_valid ? r_mem[r_rd_ptr].sbe : '0;
  assign q.is_ctrl_flow_o      = w_head_valid && r_mem[r_rd_ptr].is_ctrl_flow;
  assign q.next_entry_valid_o  = w_next_valid;
  assign q.next_entry_o        = w_next_valid ? r_mem[w_rd_ptr_nxt].sbe : '0;
  assign q.usage_o             = r_usage;

  a_depth_legal: assert property (@(posedge clk_i) is_valid_depth(DEPTH));

  // An ack alongside a flush is meaningless and dropped, so only unflushed cycles are checked.
  a_no_ack_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    (q.issue_instr_ack_i && !q.flush_i) |-> (r_usage != '0));

  a_usage_bound: assert property (@(posedge clk_i) disable iff (rst_i) r_usage <= c_FULL);

endmodule
`default_nettype wire

// File: doc/issue_entry_queue.md
# issue_entry_queue

Decoupling queue between the decode stage and the instruction reorder stage. Buffers decoded scoreboard entries (with their control-flow flag) so decode keeps running while the reorder/issue stages stall. Presents the head entry plus a one-entry lookahead, so the reorder stage can judge a swap before the head is acknowledged. Cleared on pipeline flush.

## Interface

Parameters:
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  discard all buffered entries.
- `issue_entry_i`  in  `scoreboard_entry_t`  decoded entry from decode.
- `issue_entry_valid_i`  in  1  `issue_entry_i` is valid.
- `is_ctrl_flow_i`  in  1  entry is a control-flow instruction.
- `issue_instr_ack_o`  out  1  entry accepted this cycle.
- `issue_entry_o`  out  `scoreboard_entry_t`  head entry.
- `issue_entry_valid_o`  out  1  head entry is valid.
- `is_ctrl_flow_o`  out  1  head entry's control-flow flag.
- `issue_instr_ack_i`  in  1  head consumed this cycle.
- `next_entry_o`  out  `scoreboard_entry_t`  entry behind the head.
- `next_entry_valid_o`  out  1  lookahead entry is valid.
- `usage_o`  out  $clog2(DEPTH+1)  current occupancy.

## Operation

- Storage is a circular buffer with write pointer, read pointer ($clog2(DEPTH) bits, natural wrap) and occupancy counter.
- **Accept:** `issue_instr_ack_o = issue_entry_valid_i & (usage < DEPTH) & !flush_i`. On accept, the entry is written at the write pointer and the pointer advances.
- **Full:** no push while full, even if the head is popped in the same cycle. This keeps `issue_instr_ack_i` off the path to `issue_instr_ack_o`.
- **Pop:** `issue_instr_ack_i & issue_entry_valid_o` advances the read pointer. An ack while the output is invalid is ignored and is flagged by an assertion.
- **Push and pop in the same cycle:** occupancy is unchanged and both pointers advance.
- **Head output:**
  - `issue_entry_valid_o = (usage != 0) & !flush_i`.
  - `issue_entry_o`/`is_ctrl_flow_o` come from the read-pointer slot.
  - When the output is invalid, they are driven to '0.
- **Lookahead output:**
  - `next_entry_valid_o = (usage >= 2) & !flush_i`.
  - Data comes from read pointer + 1 (mod DEPTH), and is '0 when invalid.
- **Flush:**
  - During the flush cycle, all valids and the ack are low.
  - At the edge, pointers and usage go to 0.
  - Storage contents are not cleared.
- **Flush priority:** flush overrides any push or pop in the same cycle.
- **Reset:** pointers and usage are 0, so all valid outputs are 0, all entry outputs are '0 and `usage_o` is 0. Reset has priority over flush. Reset mid-stream drops all entries.
- No bypass: an entry written in cycle N is visible earliest in cycle N+1.

## Timing

- Latency from input to head is 1 cycle when the queue is empty.
- `issue_instr_ack_o` depends combinationally only on `issue_entry_valid_i`, `flush_i` and registered occupancy.
- All outputs except `issue_instr_ack_o` are functions of registered state and `flush_i` only.
- Sustained throughput is 1 entry per cycle when not full.
- After filling, a full queue needs one pop cycle before it accepts again.

## Structure

- Add `issue_q_entry_t` (packed: `sbe`, `is_ctrl_flow`) to `ariane_pkg` next to `scoreboard_entry_t`.
- Storage is a flat array of `issue_q_entry_t` inside the module. No sub-module is needed.
- Instantiated in `issue_stage` between the decode outputs and `instr_reorder` inputs. Its lookahead ports feed the reorder swap logic.
- Assertions:
  - `DEPTH` is a power of two and ≥ 2.
  - No ack while the head is invalid.
  - `usage_o` ≤ `DEPTH`.

## Test plan

- **Reset then single push:** after reset, push entry A (rd=5) with `issue_entry_valid_i`. Ack is high that cycle; next cycle `issue_entry_valid_o`=1, `issue_entry_o.rd`=5, `next_entry_valid_o`=0, `usage_o`=1.
- **Fill to full:** with DEPTH=4 and ack_i held low, push A–E. A–D are acked, E is not; `usage_o`=4. Next cycle pop A and offer E: E is still not acked. The cycle after, E is acked.
- **Lookahead:** queue holds A (LOAD), B (ALU). Head=A and next=B, both valid. Pop A: head=B, `next_entry_valid_o`=0.
- **Wrap-around:** stream 10 entries (rd=1..10) with a simultaneous push/pop every cycle after the first. Output order is 1..10, `usage_o` stays 1, and pointers wrap twice.
- **Flush:** with 3 entries held, assert `flush_i` alongside a push and a pop. That cycle: ack_o=0 and valid_o=0. Next cycle: `usage_o`=0 and the dropped entries never appear.
- **Synchronous reset mid-stream:** with 2 entries held, assert `rst_i` for one cycle. Next cycle all outputs are 0, and a new push after reset appears 1 cycle later.
